// File: rtl/return_coin_controller_pkg.sv
`default_nettype none
// ============================================================================
// return_coin_controller_pkg : shared sizes and state encodings for the
//                              change-return controller.
// Revision 1.0
// ============================================================================
package return_coin_controller_pkg;

  localparam int c_NUM_COINS  = 3;
  localparam int c_NUM_ITEMS  = 4;
  localparam int c_TOTAL_BITS = 31;
  localparam int c_WAIT_TIME  = 100;

  typedef enum logic [0:0] {
    kStateWait   = 1'b0,
    kStateReturn = 1'b1
  } rcc_state_e;

endpackage : return_coin_controller_pkg
`default_nettype wire

// File: rtl/return_coin_controller_if.sv
`default_nettype none
// ============================================================================
// return_coin_controller_if : bundle between the next-total calculator side
//                             (master) and the return controller (slave).
// Revision 1.0
// ============================================================================
interface return_coin_controller_if #(
  parameter int kNumCoins  = return_coin_controller_pkg::c_NUM_COINS,
  parameter int kNumItems  = return_coin_controller_pkg::c_NUM_ITEMS,
  parameter int kTotalBits = return_coin_controller_pkg::c_TOTAL_BITS
);

  logic [kNumCoins-1:0]       i_input_coin;
  logic [kNumItems-1:0]       i_output_item;
  logic                       i_trigger_return;
  logic [kNumCoins-1:0][31:0] coin_value;
  logic [kTotalBits-1:0]      current_total;
  logic [31:0]                wait_time;
  logic [kNumCoins-1:0]       o_return_coin;

  modport master (
    output i_input_coin, i_output_item, i_trigger_return, coin_value, current_total,
    input  wait_time, o_return_coin
  );

  modport slave (
    input  i_input_coin, i_output_item, i_trigger_return, coin_value, current_total,
    output wait_time, o_return_coin
  );

endinterface : return_coin_controller_if
`default_nettype wire

// File: rtl/return_coin_controller_greedy_coin_select.sv
`default_nettype none
// ============================================================================
// greedy_coin_select : one-hot of the largest denomination not exceeding the
//                      balance; zero when even the smallest one is too big.
// Revision 1.0
// ============================================================================
module greedy_coin_select #(
  parameter int kNumCoins  = 3,
  parameter int kTotalBits = 31
) (
  input  wire logic [kNumCoins-1:0][31:0] i_coin_value,
  input  wire logic [kTotalBits-1:0]      i_total,
  output logic      [kNumCoins-1:0]       o_select
);

  logic [31:0] w_total;

  assign w_total = 32'(i_total);

  // Ascending scan: the last qualifying index overrides earlier ones.
  always_comb begin
    o_select = '0;
    for (int i = 0; i < kNumCoins; i++) begin
      if (i_coin_value[i] <= w_total) begin
        o_select    = '0;
        o_select[i] = 1'b1;
      end
    end
  end

endmodule : greedy_coin_select
`default_nettype wire

// File: rtl/return_coin_controller.sv
`default_nettype none
// ============================================================================
// return_coin_controller : purchase-window timer; on timeout or request it
//                          pays the balance back one coin per cycle.
// Revision 1.0
// ============================================================================
module return_coin_controller
  import return_coin_controller_pkg::*;
#(
  parameter int kNumCoins  = c_NUM_COINS,
  parameter int kNumItems  = c_NUM_ITEMS,
  parameter int kTotalBits = c_TOTAL_BITS,
  parameter int kWaitTime  = c_WAIT_TIME
) (
  input wire logic                clk,
  input wire logic                reset_n,
  return_coin_controller_if.slave bus
);

  rcc_state_e           r_state;
  logic [31:0]          r_wc;
  logic [kNumCoins-1:0] w_select;
  logic [31:0]          w_total_ext;
  logic                 w_activity;

  assign w_total_ext = 32'(bus.current_total);
  assign w_activity  = (|bus.i_input_coin) | (|bus.i_output_item);

  greedy_coin_select #(
    .kNumCoins  (kNumCoins),
    .kTotalBits (kTotalBits)
  ) u_greedy (
    .i_coin_value (bus.coin_value),
    .i_total      (bus.current_total),
    .o_select     (w_select)
  );

  // Returning nothing (counter at 0) tells upstream to drop coins and items.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= kStateWait;
      r_wc    <= 32'(kWaitTime);
    end else if (r_state == kStateWait) begin
      if (bus.i_trigger_return) begin
        r_state <= kStateReturn;
        r_wc    <= 32'd0;
      end else if (w_activity) begin
        r_wc    <= 32'(kWaitTime);
      end else if (r_wc == 32'd1) begin
        r_state <= kStateReturn;
        r_wc    <= 32'd0;
      end else begin
        r_wc    <= r_wc - 32'd1;
      end
    end else begin
      if (w_total_ext < bus.coin_value[0]) begin
        r_state <= kStateWait;
        r_wc    <= 32'(kWaitTime);
      end
    end
  end

  // Gated by state so an asynchronous reset silences the dispenser at once.
  assign bus.o_return_coin = (r_state == kStateReturn) ? w_select : '0;
  assign bus.wait_time     = r_wc;

endmodule : return_coin_controller
`default_nettype wire
